// File: rtl/game_pkg.sv
// Shared types and constants for the game round/level counter.
package game_pkg;
  localparam logic ST_PLAY = 1'b0;
  localparam logic ST_DONE = 1'b1;
  localparam int WIN_HOLD  = 0;
  localparam int WIN_PULSE = 1;

  typedef enum logic {
    PLAY = ST_PLAY,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/mod_counter.sv
// Modulo counter with a runtime limit; wraps to zero once q >= limit.
module mod_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [SIZE-1:0] limit,
  output logic [SIZE-1:0] q,
  output logic            wrap
);
  // >= so a lowered limit wraps instead of running on to all-ones
  assign wrap = (q >= limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= wrap ? '0 : q + SIZE'(1);
    end
  end
endmodule

// File: rtl/round_level_counter.sv
// Round counter with level progression and a terminal DONE state.
module round_level_counter
  import game_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int LVL_SIZE  = 2,
  parameter int MAX_LEVEL = 3,
  parameter int WIN_MODE  = 0
) (
  input  logic                clk,
  input  logic                R,
  input  logic                clear,
  input  logic                E,
  input  logic [SIZE-1:0]     data,
  output logic [SIZE-1:0]     ROUND,
  output logic [LVL_SIZE-1:0] LEVEL,
  output logic                win,
  output logic                done
);
  state_t              state, state_n;
  logic [LVL_SIZE-1:0] level_n;
  logic                win_n, done_n;
  logic                wrap, adv;

  assign adv = E & ~clear & (state == PLAY);

  mod_counter #(.SIZE(SIZE)) u_round (
    .clk   (clk),
    .rst   (R),
    .clr   (clear),
    .en    (adv),
    .limit (data),
    .q     (ROUND),
    .wrap  (wrap)
  );

  always_comb begin
    state_n = state;
    level_n = LEVEL;
    done_n  = done;
    win_n   = (WIN_MODE == WIN_HOLD) ? win : 1'b0;
    if (clear) begin
      state_n = PLAY;
      level_n = '0;
      done_n  = 1'b0;
      win_n   = 1'b0;
    end else begin
      unique case (state)
        PLAY: begin
          if (E) begin
            win_n = wrap;
            if (wrap) begin
              if (LEVEL == LVL_SIZE'(MAX_LEVEL)) begin
                done_n  = 1'b1;
                state_n = DONE;
              end else begin
                level_n = LEVEL + LVL_SIZE'(1);
              end
            end
          end
        end
        DONE: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state <= PLAY;
      LEVEL <= '0;
      win   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      LEVEL <= level_n;
      win   <= win_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_round_level_counter.sv
// Directed bench for round_level_counter in hold and pulse win modes.
module tb_round_level_counter;
  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       clear = 1'b0;
  logic       E = 1'b0;
  logic [3:0] data = 4'd3;
  logic [3:0] round0, round1;
  logic [1:0] level0, level1;
  logic       win0, win1, done0, done1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  round_level_counter #(.WIN_MODE(0)) dut0 (
    .clk(clk), .R(R), .clear(clear), .E(E), .data(data),
    .ROUND(round0), .LEVEL(level0), .win(win0), .done(done0)
  );

  round_level_counter #(.WIN_MODE(1)) dut1 (
    .clk(clk), .R(R), .clear(clear), .E(E), .data(data),
    .ROUND(round1), .LEVEL(level1), .win(win1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present E/clear for one edge, then sample 1 time unit after it.
  task automatic tick(input logic e, input logic c);
    @(negedge clk);
    E = e;
    clear = c;
    @(posedge clk);
    #1;
    E = 1'b0;
    clear = 1'b0;
  endtask

  task automatic both(input string tag, input logic [3:0] r,
                      input logic [1:0] l, input logic d);
    chk({tag, " round0"}, 32'(round0), 32'(r));
    chk({tag, " round1"}, 32'(round1), 32'(r));
    chk({tag, " level0"}, 32'(level0), 32'(l));
    chk({tag, " level1"}, 32'(level1), 32'(l));
    chk({tag, " done0"}, 32'(done0), 32'(d));
    chk({tag, " done1"}, 32'(done1), 32'(d));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    R = 1'b0;
    #1;
    both("reset", 4'd0, 2'd0, 1'b0);
    chk("reset win0", 32'(win0), 32'd0);
    chk("reset win1", 32'(win1), 32'd0);

    // data=3: four rounds, ROUND 1,2,3,0
    data = 4'd3;
    tick(1, 0); both("r1", 4'd1, 2'd0, 1'b0);
    tick(1, 0); both("r2", 4'd2, 2'd0, 1'b0);
    tick(1, 0); both("r3", 4'd3, 2'd0, 1'b0);
    chk("r3 win0", 32'(win0), 32'd0);
    tick(1, 0); both("r4", 4'd0, 2'd1, 1'b0);
    chk("r4 win0", 32'(win0), 32'd1);
    chk("r4 win1", 32'(win1), 32'd1);
    tick(0, 0);
    chk("idle1 win0", 32'(win0), 32'd1);
    chk("idle1 win1", 32'(win1), 32'd0);
    tick(0, 0);
    chk("idle2 win0", 32'(win0), 32'd1);
    chk("idle2 round0", 32'(round0), 32'd0);
    tick(1, 0); both("next", 4'd1, 2'd1, 1'b0);
    chk("next win0", 32'(win0), 32'd0);

    // Pulse-mode round with data=2
    tick(0, 1); both("clr1", 4'd0, 2'd0, 1'b0);
    data = 4'd2;
    tick(1, 0); chk("p1 win1", 32'(win1), 32'd0);
    tick(1, 0); chk("p2 win1", 32'(win1), 32'd0);
    tick(1, 0); both("p3", 4'd0, 2'd1, 1'b0);
    chk("p3 win1", 32'(win1), 32'd1);
    tick(0, 0);
    chk("p4 win1", 32'(win1), 32'd0);
    chk("p4 win0", 32'(win0), 32'd1);

    // data=0: every E wins, game completes on the 4th
    tick(0, 1); both("clr2", 4'd0, 2'd0, 1'b0);
    data = 4'd0;
    tick(1, 0); both("g1", 4'd0, 2'd1, 1'b0);
    chk("g1 win1", 32'(win1), 32'd1);
    tick(1, 0); both("g2", 4'd0, 2'd2, 1'b0);
    tick(1, 0); both("g3", 4'd0, 2'd3, 1'b0);
    tick(1, 0); both("g4", 4'd0, 2'd3, 1'b1);
    chk("g4 win0", 32'(win0), 32'd1);
    chk("g4 win1", 32'(win1), 32'd1);
    chk("g4 state", 32'(dut0.state), 32'd1);
    data = 4'd5;
    for (int i = 0; i < 3; i++) tick(1, 0);
    both("dn", 4'd0, 2'd3, 1'b1);
    chk("dn win0", 32'(win0), 32'd1);
    chk("dn win1", 32'(win1), 32'd0);

    // clear and E together in DONE: clear wins, E dropped
    tick(1, 1); both("ce", 4'd0, 2'd0, 1'b0);
    chk("ce win0", 32'(win0), 32'd0);
    chk("ce state", 32'(dut1.state), 32'd0);

    // Target lowered below ROUND
    data = 4'd9;
    for (int i = 0; i < 7; i++) tick(1, 0);
    both("t7", 4'd7, 2'd0, 1'b0);
    data = 4'd4;
    tick(1, 0); both("tw", 4'd0, 2'd1, 1'b0);
    chk("tw win0", 32'(win0), 32'd1);
    tick(1, 0); both("ta", 4'd1, 2'd1, 1'b0);

    // data=15: all-ones round is reached, next E wins
    tick(0, 1);
    data = 4'd15;
    for (int i = 0; i < 15; i++) tick(1, 0);
    both("f15", 4'd15, 2'd0, 1'b0);
    chk("f15 win0", 32'(win0), 32'd0);
    tick(1, 0); both("f16", 4'd0, 2'd1, 1'b0);
    chk("f16 win1", 32'(win1), 32'd1);

    // Async reset at ROUND=5, LEVEL=2
    tick(0, 1);
    data = 4'd0;
    tick(1, 0);
    tick(1, 0);
    data = 4'd9;
    for (int i = 0; i < 5; i++) tick(1, 0);
    both("pre", 4'd5, 2'd2, 1'b0);
    @(negedge clk);
    #2;
    R = 1'b1;
    #1;
    both("ar", 4'd0, 2'd0, 1'b0);
    chk("ar win0", 32'(win0), 32'd0);
    chk("ar win1", 32'(win1), 32'd0);
    @(negedge clk);
    R = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
